// File: rtl/regfile_port_ctrl_if.sv
// regfile_port_ctrl_if: core-side read-request, response and write-back channels of the register file controller
interface regfile_port_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-6:0] rd_bank;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-6:0] wb_bank;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  modport master (
    output rd_req_valid, rd_bank, rs1, rs2, rsp_ready, wb_valid, wb_bank, wb_rd, wb_data,
    input  rd_req_ready, rsp_valid, rs1_data, rs2_data, wb_ready
  );
  modport slave (
    input  rd_req_valid, rd_bank, rs1, rs2, rsp_ready, wb_valid, wb_bank, wb_rd, wb_data,
    output rd_req_ready, rsp_valid, rs1_data, rs2_data, wb_ready
  );
endinterface

// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: drives a dual-port BSRAM register file, zero-filling it after reset and serving rs1/rs2 reads and rd writes
module regfile_port_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  regfile_port_ctrl_if.slave bus,
  output logic              clear_done,
  output logic [ADDR_W-1:0] ram_ada,
  output logic [DATA_W-1:0] ram_dina,
  output logic              ram_wrea,
  output logic              ram_cea,
  output logic [ADDR_W-1:0] ram_adb,
  output logic              ram_ceb,
  input  logic [DATA_W-1:0] ram_douta,
  input  logic [DATA_W-1:0] ram_doutb
);
  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RSP} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              clear_done_q, clear_done_d;
  logic              rs1_zero_q, rs1_zero_d;
  logic              rs2_zero_q, rs2_zero_d;
  logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
  logic              clearing, rd_fire, wb_fire, wb_wr;

  assign clearing         = state_q == CLEAR;
  assign bus.wb_ready     = !clearing;
  assign bus.rd_req_ready = state_q == IDLE && !bus.wb_valid;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rs1_data     = rs1_data_q;
  assign bus.rs2_data     = rs2_data_q;
  assign clear_done       = clear_done_q;

  always_comb begin
    rd_fire  = bus.rd_req_valid && bus.rd_req_ready;
    wb_fire  = bus.wb_valid && bus.wb_ready;
    wb_wr    = wb_fire && |bus.wb_rd;
    ram_wrea = clearing || wb_wr;
    ram_cea  = clearing || wb_wr || rd_fire;
    ram_ada  = clearing ? clr_cnt_q : wb_wr ? {bus.wb_bank, bus.wb_rd} : {bus.rd_bank, bus.rs1};
    ram_dina = clearing ? '0 : bus.wb_data;
    ram_adb  = {bus.rd_bank, bus.rs2};
    ram_ceb  = rd_fire;
  end

  // A write during WAIT lands at the same edge as the capture, so the capture sees pre-write data.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    rsp_valid_d  = rsp_valid_q;
    clear_done_d = clear_done_q;
    rs1_zero_d   = rs1_zero_q;
    rs2_zero_d   = rs2_zero_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (&clr_cnt_q) begin
          state_d      = IDLE;
          clear_done_d = 1'b1;
        end
      end
      IDLE: if (rd_fire) begin
        state_d    = WAIT;
        rs1_zero_d = ~|bus.rs1;
        rs2_zero_d = ~|bus.rs2;
      end
      WAIT: begin
        rs1_data_d  = rs1_zero_q ? '0 : ram_douta;
        rs2_data_d  = rs2_zero_q ? '0 : ram_doutb;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RSP: if (bus.rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= '0;
      rsp_valid_q  <= 1'b0;
      clear_done_q <= 1'b0;
      rs1_zero_q   <= 1'b0;
      rs2_zero_q   <= 1'b0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      clear_done_q <= clear_done_d;
      rs1_zero_q   <= rs1_zero_d;
      rs2_zero_q   <= rs2_zero_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
    end
  end
endmodule

// File: tb/tb_regfile_port_ctrl.sv
// tb_regfile_port_ctrl: directed bench for regfile_port_ctrl with a behavioural dual-port RAM
module tb_regfile_port_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear_done;
  logic [5:0]  ram_ada, ram_adb;
  logic [31:0] ram_dina, ram_douta, ram_doutb;
  logic        ram_wrea, ram_cea, ram_ceb;
  logic [31:0] mem [64];
  int          tests = 0;
  int          fails = 0;

  regfile_port_ctrl_if #(.DATA_W(32), .ADDR_W(6)) bus ();

  regfile_port_ctrl #(.DATA_W(32), .ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .bus(bus), .clear_done(clear_done),
    .ram_ada(ram_ada), .ram_dina(ram_dina), .ram_wrea(ram_wrea), .ram_cea(ram_cea),
    .ram_adb(ram_adb), .ram_ceb(ram_ceb), .ram_douta(ram_douta), .ram_doutb(ram_doutb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_cea) begin
      if (ram_wrea) mem[ram_ada] <= ram_dina;
      else ram_douta <= mem[ram_ada];
    end
    if (ram_ceb) ram_doutb <= mem[ram_adb];
  end

  task automatic do_write(input logic bank, input logic [4:0] rd, input logic [31:0] data,
                          output logic we_seen, output logic rdy_seen);
    bus.wb_bank = bank; bus.wb_rd = rd; bus.wb_data = data; bus.wb_valid = 1'b1;
    @(negedge clk);
    we_seen = ram_wrea;
    rdy_seen = bus.wb_ready;
    @(posedge clk); #1;
    bus.wb_valid = 1'b0;
  endtask

  task automatic do_read(input logic bank, input logic [4:0] r1, input logic [4:0] r2,
                         output logic [31:0] d1, output logic [31:0] d2, output int lat);
    logic acc = 1'b0;
    bus.rd_bank = bank; bus.rs1 = r1; bus.rs2 = r2; bus.rd_req_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = bus.rd_req_ready;
      @(posedge clk); #1;
    end
    bus.rd_req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!acc) lat = 99;
    d1 = bus.rs1_data;
    d2 = bus.rs2_data;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int bad_addr = 0, bad_rdy = 0, bad_done = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.rs1_data !== 32'h0 || bus.rs2_data !== 32'h0 || clear_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: rsp_valid=%b rs1=%h rs2=%h clear_done=%b, want 0/0/0/0",
               bus.rsp_valid, bus.rs1_data, bus.rs2_data, clear_done);
    end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ram_wrea !== 1'b1 || ram_ada !== 6'(i) || ram_dina !== 32'h0 || ram_cea !== 1'b1) bad_addr++;
      if (bus.rd_req_ready !== 1'b0 || bus.wb_ready !== 1'b0) bad_rdy++;
      if (clear_done !== 1'b0) bad_done++;
      @(posedge clk);
    end
    #1;
    tests++;
    if (bad_addr != 0) begin
      fails++;
      $display("FAIL clear_sweep: %0d bad cycles, want 0", bad_addr);
    end
    tests++;
    if (bad_rdy != 0 || bad_done != 0) begin
      fails++;
      $display("FAIL clear_ready: %0d ready cycles, %0d early done, want 0/0", bad_rdy, bad_done);
    end
    tests++;
    if (clear_done !== 1'b1 || bus.wb_ready !== 1'b1) begin
      fails++;
      $display("FAIL clear_done: clear_done=%b wb_ready=%b, want 1/1", clear_done, bus.wb_ready);
    end
  endtask

  task automatic test_write_read();
    logic we, rdy;
    logic [31:0] d1, d2;
    int lat;
    do_write(1'b0, 5'd5, 32'hDEADBEEF, we, rdy);
    tests++;
    if (we !== 1'b1 || rdy !== 1'b1) begin
      fails++;
      $display("FAIL write_x5: wrea=%b ready=%b, want 1/1", we, rdy);
    end
    do_write(1'b1, 5'd5, 32'h11111111, we, rdy);
    do_read(1'b0, 5'd5, 5'd0, d1, d2, lat);
    tests++;
    if (d1 !== 32'hDEADBEEF || d2 !== 32'h0 || lat != 2) begin
      fails++;
      $display("FAIL read_x5: rs1=%h rs2=%h lat=%0d, want deadbeef/0/2", d1, d2, lat);
    end
    do_read(1'b1, 5'd0, 5'd5, d1, d2, lat);
    tests++;
    if (d1 !== 32'h0 || d2 !== 32'h11111111 || lat != 2) begin
      fails++;
      $display("FAIL read_bank1: rs1=%h rs2=%h lat=%0d, want 0/11111111/2", d1, d2, lat);
    end
  endtask

  task automatic test_x0();
    logic we, rdy;
    logic [31:0] d1, d2;
    int lat;
    do_write(1'b0, 5'd0, 32'h12345678, we, rdy);
    tests++;
    if (we !== 1'b0 || rdy !== 1'b1 || mem[0] !== 32'h0) begin
      fails++;
      $display("FAIL write_x0: wrea=%b ready=%b mem0=%h, want 0/1/0", we, rdy, mem[0]);
    end
    do_read(1'b0, 5'd0, 5'd0, d1, d2, lat);
    tests++;
    if (d1 !== 32'h0 || d2 !== 32'h0 || lat != 2) begin
      fails++;
      $display("FAIL read_x0: rs1=%h rs2=%h lat=%0d, want 0/0/2", d1, d2, lat);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] d1, d2;
    int lat;
    bus.wb_bank = 1'b0; bus.wb_rd = 5'd7; bus.wb_data = 32'hA5A5A5A5; bus.wb_valid = 1'b1;
    bus.rd_bank = 1'b0; bus.rs1 = 5'd7; bus.rs2 = 5'd5; bus.rd_req_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.wb_ready !== 1'b1 || bus.rd_req_ready !== 1'b0 || ram_wrea !== 1'b1 || ram_ceb !== 1'b0) begin
      fails++;
      $display("FAIL conflict: wb_ready=%b rd_req_ready=%b wrea=%b ceb=%b, want 1/0/1/0",
               bus.wb_ready, bus.rd_req_ready, ram_wrea, ram_ceb);
    end
    @(posedge clk); #1;
    bus.wb_valid = 1'b0;
    do_read(1'b0, 5'd7, 5'd5, d1, d2, lat);
    tests++;
    if (d1 !== 32'hA5A5A5A5 || d2 !== 32'hDEADBEEF || lat != 2) begin
      fails++;
      $display("FAIL conflict_read: rs1=%h rs2=%h lat=%0d, want a5a5a5a5/deadbeef/2", d1, d2, lat);
    end
  endtask

  task automatic test_wait_write();
    logic we, rdy;
    logic [31:0] d1, d2;
    int lat;
    do_write(1'b0, 5'd3, 32'd7, we, rdy);
    bus.rd_bank = 1'b0; bus.rs1 = 5'd3; bus.rs2 = 5'd0; bus.rd_req_valid = 1'b1;
    @(negedge clk);
    rdy = bus.rd_req_ready;
    @(posedge clk); #1;
    bus.rd_req_valid = 1'b0;
    bus.wb_bank = 1'b0; bus.wb_rd = 5'd3; bus.wb_data = 32'd9; bus.wb_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (rdy !== 1'b1 || bus.wb_ready !== 1'b1 || ram_wrea !== 1'b1) begin
      fails++;
      $display("FAIL wait_write: rd_ready=%b wb_ready=%b wrea=%b, want 1/1/1", rdy, bus.wb_ready, ram_wrea);
    end
    @(posedge clk); #1;
    bus.wb_valid = 1'b0;
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rs1_data !== 32'd7) begin
      fails++;
      $display("FAIL wait_old: rsp_valid=%b rs1=%h, want 1/7", bus.rsp_valid, bus.rs1_data);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    do_read(1'b0, 5'd3, 5'd0, d1, d2, lat);
    tests++;
    if (d1 !== 32'd9 || lat != 2) begin
      fails++;
      $display("FAIL wait_new: rs1=%h lat=%0d, want 9/2", d1, lat);
    end
  endtask

  task automatic test_rsp_hold_reset();
    int bad = 0, n = 0, lat;
    logic [31:0] d1, d2;
    bus.rd_bank = 1'b0; bus.rs1 = 5'd3; bus.rs2 = 5'd5; bus.rd_req_valid = 1'b1;
    @(posedge clk); #1;
    bus.rd_req_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      bus.wb_bank = 1'b0; bus.wb_rd = 5'd3; bus.wb_data = 32'(100 + i); bus.wb_valid = 1'b1;
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rs1_data !== 32'd9 || bus.rs2_data !== 32'hDEADBEEF || ram_wrea !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    bus.wb_valid = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rsp_hold: %0d unstable cycles, want 0", bad);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.rs1_data !== 32'h0 || clear_done !== 1'b0 ||
        ram_wrea !== 1'b1 || ram_ada !== 6'd0 || bus.wb_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: rsp_valid=%b rs1=%h done=%b wrea=%b ada=%0d wb_ready=%b, want 0/0/0/1/0/0",
               bus.rsp_valid, bus.rs1_data, clear_done, ram_wrea, ram_ada, bus.wb_ready);
    end
    while (!clear_done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (n != 64) begin
      fails++;
      $display("FAIL reclear_len: %0d cycles, want 64", n);
    end
    do_read(1'b0, 5'd3, 5'd5, d1, d2, lat);
    tests++;
    if (d1 !== 32'h0 || d2 !== 32'h0 || lat != 2) begin
      fails++;
      $display("FAIL read_after_clear: rs1=%h rs2=%h lat=%0d, want 0/0/2", d1, d2, lat);
    end
  endtask

  initial begin
    bus.rd_req_valid = 1'b0; bus.rd_bank = 1'b0; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    bus.rsp_ready = 1'b0; bus.wb_valid = 1'b0; bus.wb_bank = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'h0;
    test_reset();
    test_write_read();
    test_x0();
    test_conflict();
    test_wait_write();
    test_rsp_hold_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
